// File: rtl/ahb_multi_slave_interconnect.sv
// Single-master, N-slave AHB-Lite interconnect with mask/base address decode,
// a registered data-phase response mux and a built-in ERROR default slave.
module ahb_multi_slave_interconnect #(
  parameter int NUM_SLAVES = 3,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_BASE = {32'h2000_0000, 32'h1000_0000, 32'h0000_0000},
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_MASK = {3{32'hF000_0000}}
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [ADDR_W-1:0]            haddr_i,
  input  logic [1:0]                   htrans_i,
  input  logic                         hwrite_i,
  input  logic [2:0]                   hsize_i,
  input  logic [3:0]                   hprot_i,
  input  logic [DATA_W-1:0]            hwdata_i,
  input  logic                         is_signed_i,
  output logic [DATA_W-1:0]            hr_data_o,
  output logic                         hready_o,
  output logic                         hresp_o,
  output logic [NUM_SLAVES-1:0]        hsel_o,
  output logic [ADDR_W-1:0]            haddr_o,
  output logic [1:0]                   htrans_o,
  output logic                         hwrite_o,
  output logic [2:0]                   hsize_o,
  output logic [3:0]                   hprot_o,
  output logic                         is_signed_o,
  output logic [DATA_W-1:0]            hwdata_o,
  output logic                         hready_s_o,
  input  logic [NUM_SLAVES*DATA_W-1:0] hrdata_s_i,
  input  logic [NUM_SLAVES-1:0]        hreadyout_s_i,
  input  logic [NUM_SLAVES-1:0]        hresp_s_i,
  output logic [15:0]                  err_count_o
);

  localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

  localparam logic [1:0] DS_IDLE = 2'd0;
  localparam logic [1:0] DS_ERR1 = 2'd1;
  localparam logic [1:0] DS_ERR2 = 2'd2;

  localparam logic [1:0] SEL_NONE = 2'd0;
  localparam logic [1:0] SEL_SLV  = 2'd1;
  localparam logic [1:0] SEL_DEF  = 2'd2;

  logic [NUM_SLAVES-1:0] hit;
  logic [DATA_W-1:0]     rdata_arr [NUM_SLAVES];
  logic                  any_hit;
  logic [IDX_W-1:0]      win_idx;
  logic                  hready_int;
  logic                  unmapped_req;

  logic [1:0]       sel_kind_q, sel_kind_d;
  logic [IDX_W-1:0] sel_idx_q, sel_idx_d;
  logic [1:0]       state_q, state_d;
  logic [15:0]      err_q, err_d;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SLAVES; gi++) begin : g_slot
      assign hit[gi] = ((haddr_i & SLV_MASK[gi*ADDR_W +: ADDR_W]) == SLV_BASE[gi*ADDR_W +: ADDR_W]);
      assign rdata_arr[gi] = hrdata_s_i[gi*DATA_W +: DATA_W];
    end
  endgenerate

  // Scan downwards so the lowest-indexed hit is the last assignment and wins.
  always_comb begin
    win_idx = '0;
    any_hit = |hit;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if (hit[i]) win_idx = IDX_W'(i);
    end
  end

  always_comb begin
    hsel_o = '0;
    if (any_hit) hsel_o[win_idx] = 1'b1;
  end

  assign haddr_o     = haddr_i;
  assign htrans_o    = htrans_i;
  assign hwrite_o    = hwrite_i;
  assign hsize_o     = hsize_i;
  assign hprot_o     = hprot_i;
  assign is_signed_o = is_signed_i;
  assign hwdata_o    = hwdata_i;
  assign hready_s_o  = hready_int;
  assign hready_o    = hready_int;

  always_comb begin
    hr_data_o  = '0;
    hready_int = 1'b1;
    hresp_o    = 1'b0;
    case (sel_kind_q)
      SEL_SLV: begin
        hr_data_o  = rdata_arr[sel_idx_q];
        hready_int = hreadyout_s_i[sel_idx_q];
        hresp_o    = hresp_s_i[sel_idx_q];
      end
      SEL_DEF: begin
        hready_int = (state_q != DS_ERR1);
        hresp_o    = 1'b1;
      end
      default: ;
    endcase
  end

  assign unmapped_req = hready_int & htrans_i[1] & ~any_hit;

  always_comb begin
    sel_kind_d = sel_kind_q;
    sel_idx_d  = sel_idx_q;
    if (hready_int) begin
      if (!htrans_i[1]) begin
        sel_kind_d = SEL_NONE;
      end else if (any_hit) begin
        sel_kind_d = SEL_SLV;
        sel_idx_d  = win_idx;
      end else begin
        sel_kind_d = SEL_DEF;
      end
    end
  end

  // ERR1 holds hready low, so an unmapped accept can only come from IDLE or ERR2.
  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    case (state_q)
      DS_IDLE: if (unmapped_req) state_d = DS_ERR1;
      DS_ERR1: state_d = DS_ERR2;
      DS_ERR2: state_d = unmapped_req ? DS_ERR1 : DS_IDLE;
      default: state_d = DS_IDLE;
    endcase
    if (unmapped_req && (err_q != 16'hFFFF)) err_d = err_q + 16'd1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sel_kind_q <= SEL_NONE;
      sel_idx_q  <= '0;
      state_q    <= DS_IDLE;
      err_q      <= '0;
    end else begin
      sel_kind_q <= sel_kind_d;
      sel_idx_q  <= sel_idx_d;
      state_q    <= state_d;
      err_q      <= err_d;
    end
  end

  assign err_count_o = err_q;

endmodule

// File: tb/tb_ahb_multi_slave_interconnect.sv
// Bench for ahb_multi_slave_interconnect: directed scenarios plus a randomized
// run scored against a transaction-level reference model.
module tb_ahb_multi_slave_interconnect;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [3:0]  hprot;
  logic [31:0] hwdata;
  logic        is_signed;
  logic [95:0] hrdata_s;
  logic [2:0]  hreadyout_s;
  logic [2:0]  hresp_s;

  logic [31:0] hr_data, haddr_b, hwdata_b;
  logic        hready, hresp, hwrite_b, is_signed_b, hready_b;
  logic [2:0]  hsel, hsize_b;
  logic [1:0]  htrans_b;
  logic [3:0]  hprot_b;
  logic [15:0] err_count;

  logic [31:0] ov_hr_data, ov_haddr_b, ov_hwdata_b;
  logic        ov_hready, ov_hresp, ov_hwrite_b, ov_is_signed_b, ov_hready_b;
  logic [2:0]  ov_hsel, ov_hsize_b;
  logic [1:0]  ov_htrans_b;
  logic [3:0]  ov_hprot_b;
  logic [15:0] ov_err_count;

  int checks = 0;
  int errors = 0;

  bit [31:0] base_m [3] = '{32'h0000_0000, 32'h1000_0000, 32'h2000_0000};
  bit [31:0] mask_m [3] = '{32'hF000_0000, 32'hF000_0000, 32'hF000_0000};

  always #5 clk = ~clk;

  ahb_multi_slave_interconnect dut (
    .clk_i(clk), .rst_ni(rst_n),
    .haddr_i(haddr), .htrans_i(htrans), .hwrite_i(hwrite), .hsize_i(hsize),
    .hprot_i(hprot), .hwdata_i(hwdata), .is_signed_i(is_signed),
    .hr_data_o(hr_data), .hready_o(hready), .hresp_o(hresp), .hsel_o(hsel),
    .haddr_o(haddr_b), .htrans_o(htrans_b), .hwrite_o(hwrite_b), .hsize_o(hsize_b),
    .hprot_o(hprot_b), .is_signed_o(is_signed_b), .hwdata_o(hwdata_b),
    .hready_s_o(hready_b), .hrdata_s_i(hrdata_s), .hreadyout_s_i(hreadyout_s),
    .hresp_s_i(hresp_s), .err_count_o(err_count)
  );

  // Overlapping map: slot0 matches every address.
  ahb_multi_slave_interconnect #(
    .SLV_MASK({32'hF000_0000, 32'hF000_0000, 32'h0000_0000})
  ) dut_ov (
    .clk_i(clk), .rst_ni(rst_n),
    .haddr_i(haddr), .htrans_i(htrans), .hwrite_i(hwrite), .hsize_i(hsize),
    .hprot_i(hprot), .hwdata_i(hwdata), .is_signed_i(is_signed),
    .hr_data_o(ov_hr_data), .hready_o(ov_hready), .hresp_o(ov_hresp), .hsel_o(ov_hsel),
    .haddr_o(ov_haddr_b), .htrans_o(ov_htrans_b), .hwrite_o(ov_hwrite_b), .hsize_o(ov_hsize_b),
    .hprot_o(ov_hprot_b), .is_signed_o(ov_is_signed_b), .hwdata_o(ov_hwdata_b),
    .hready_s_o(ov_hready_b), .hrdata_s_i(hrdata_s), .hreadyout_s_i(hreadyout_s),
    .hresp_s_i(hresp_s), .err_count_o(ov_err_count)
  );

  function automatic int ref_decode(input logic [31:0] a);
    for (int k = 0; k < 3; k++) begin
      if ((a & mask_m[k]) == base_m[k]) return k;
    end
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n  = 1'b0;
    htrans = 2'b00;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; haddr = '0; htrans = 2'b00; hwrite = 1'b0; hsize = 3'd2;
    hprot = 4'h3; hwdata = '0; is_signed = 1'b0; hrdata_s = '0;
    hreadyout_s = 3'b111; hresp_s = 3'b000;
    @(negedge clk);
    checks++;
    if (hready !== 1'b1 || hresp !== 1'b0 || hr_data !== 32'h0 || err_count !== 16'h0) begin
      errors++;
      $display("FAIL reset: got hready=%b hresp=%b hr_data=%h err=%0d want 1 0 0 0",
               hready, hresp, hr_data, err_count);
    end
    tick();
    rst_n = 1'b1;
    $display("test_reset done");
  endtask

  task automatic test_read();
    haddr = 32'h1000_0004; htrans = 2'b10; hwrite = 1'b0;
    hrdata_s = {32'h0, 32'hDEAD_BEEF, 32'h0};
    @(negedge clk);
    checks++;
    if (hsel !== 3'b010 || haddr_b !== 32'h1000_0004 || htrans_b !== 2'b10) begin
      errors++;
      $display("FAIL read_addr: got hsel=%b haddr=%h htrans=%b want 010 10000004 10", hsel, haddr_b, htrans_b);
    end
    tick();
    htrans = 2'b00;
    @(negedge clk);
    checks++;
    if (hr_data !== 32'hDEAD_BEEF || hready !== 1'b1 || hresp !== 1'b0) begin
      errors++;
      $display("FAIL read_data: got %h/%b/%b want deadbeef/1/0", hr_data, hready, hresp);
    end
    tick();
    $display("test_read done");
  endtask

  task automatic test_wait_states();
    haddr = 32'h0000_0010; htrans = 2'b10;
    @(negedge clk);
    checks++;
    if (hsel !== 3'b001) begin
      errors++; $display("FAIL wait_hsel0: got %b want 001", hsel);
    end
    tick();
    hreadyout_s = 3'b110;
    haddr = 32'h2000_0000; htrans = 2'b10;
    @(negedge clk);
    checks++;
    if (hready !== 1'b0 || hready_b !== 1'b0 || hsel !== 3'b100) begin
      errors++; $display("FAIL wait_1: got hready=%b bc=%b hsel=%b want 0 0 100", hready, hready_b, hsel);
    end
    tick();
    @(negedge clk);
    checks++;
    if (hready !== 1'b0) begin
      errors++; $display("FAIL wait_2: got hready=%b want 0", hready);
    end
    tick();
    hreadyout_s = 3'b111;
    hrdata_s = {32'h2222_2222, 32'h0, 32'h0A0A_0A0A};
    @(negedge clk);
    checks++;
    if (hready !== 1'b1 || hr_data !== 32'h0A0A_0A0A) begin
      errors++; $display("FAIL wait_done: got hready=%b data=%h want 1 0a0a0a0a", hready, hr_data);
    end
    tick();
    htrans = 2'b00;
    @(negedge clk);
    checks++;
    if (hr_data !== 32'h2222_2222 || hready !== 1'b1) begin
      errors++; $display("FAIL wait_next: got data=%h hready=%b want 22222222 1", hr_data, hready);
    end
    tick();
    $display("test_wait_states done");
  endtask

  task automatic test_unmapped_write();
    haddr = 32'h8000_0000; htrans = 2'b10; hwrite = 1'b1;
    @(negedge clk);
    checks++;
    if (hsel !== 3'b000 || hwrite_b !== 1'b1) begin
      errors++; $display("FAIL unmapped_hsel: got hsel=%b hwrite=%b want 000 1", hsel, hwrite_b);
    end
    tick();
    htrans = 2'b00; hwrite = 1'b0; hwdata = 32'h1234_5678;
    @(negedge clk);
    checks++;
    if (hready !== 1'b0 || hresp !== 1'b1 || hr_data !== 32'h0 || hwdata_b !== 32'h1234_5678) begin
      errors++; $display("FAIL unmapped_err1: got %b/%b/%h wdata=%h want 0/1/0 12345678",
                         hready, hresp, hr_data, hwdata_b);
    end
    tick();
    @(negedge clk);
    checks++;
    if (hready !== 1'b1 || hresp !== 1'b1) begin
      errors++; $display("FAIL unmapped_err2: got %b/%b want 1/1", hready, hresp);
    end
    tick();
    @(negedge clk);
    checks++;
    if (hready !== 1'b1 || hresp !== 1'b0 || err_count !== 16'd1) begin
      errors++; $display("FAIL unmapped_okay: got %b/%b err=%0d want 1/0 err=1", hready, hresp, err_count);
    end
    $display("test_unmapped_write done");
  endtask

  task automatic test_back_to_back();
    logic [1:0] seq_rdy [5] = '{2'b01, 2'b11, 2'b01, 2'b11, 2'b10};
    apply_reset();
    haddr = 32'h9000_0000; htrans = 2'b10;
    tick();
    haddr = 32'hA000_0000;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if ({hready, hresp} !== seq_rdy[c]) begin
        errors++; $display("FAIL b2b_cycle%0d: got hready/hresp=%b%b want %b", c, hready, hresp, seq_rdy[c]);
      end
      tick();
      if (c == 1) htrans = 2'b00;
    end
    checks++;
    if (err_count !== 16'd2) begin
      errors++; $display("FAIL b2b_count: got %0d want 2", err_count);
    end
    $display("test_back_to_back done");
  endtask

  task automatic test_reset_in_err();
    haddr = 32'h8000_0000; htrans = 2'b10;
    tick();
    htrans = 2'b00;
    #1;
    checks++;
    if (hready !== 1'b0 || err_count === 16'd0) begin
      errors++; $display("FAIL rst_err_pre: got hready=%b err=%0d want 0 nonzero", hready, err_count);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (hready !== 1'b1 || hresp !== 1'b0 || err_count !== 16'd0) begin
      errors++; $display("FAIL rst_err_async: got %b/%b err=%0d want 1/0 err=0", hready, hresp, err_count);
    end
    tick();
    rst_n = 1'b1;
    haddr = 32'h2000_0000; htrans = 2'b10; hrdata_s = {32'h600D_F00D, 64'h0};
    tick();
    htrans = 2'b00;
    @(negedge clk);
    checks++;
    if (hr_data !== 32'h600D_F00D || hready !== 1'b1 || hresp !== 1'b0) begin
      errors++; $display("FAIL rst_err_read: got %h/%b/%b want 600df00d/1/0", hr_data, hready, hresp);
    end
    tick();
    $display("test_reset_in_err done");
  endtask

  task automatic test_overlap();
    haddr = 32'h1000_0000; htrans = 2'b10; hrdata_s = {32'h0, 32'h1111_1111, 32'h0F0F_0F0F};
    @(negedge clk);
    checks++;
    if (ov_hsel !== 3'b001) begin
      errors++; $display("FAIL overlap_hsel: got %b want 001", ov_hsel);
    end
    tick();
    htrans = 2'b00;
    @(negedge clk);
    checks++;
    if (ov_hr_data !== 32'h0F0F_0F0F || ov_err_count !== 16'd0) begin
      errors++; $display("FAIL overlap_data: got %h err=%0d want 0f0f0f0f err=0", ov_hr_data, ov_err_count);
    end
    tick();
    $display("test_overlap done");
  endtask

  task automatic test_random();
    int tgt = -1;
    int err_left = 0;
    int exp_err = 0;
    int d;
    logic [2:0]  e_hsel;
    logic        e_rdy, e_rsp;
    logic [31:0] e_data;
    int bad = 0;
    apply_reset();
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 4))
        0: haddr = 32'h0000_0000 | ($urandom & 32'h0FFF_FFFF);
        1: haddr = 32'h1000_0000 | ($urandom & 32'h0FFF_FFFF);
        2: haddr = 32'h2000_0000 | ($urandom & 32'h0FFF_FFFF);
        default: haddr = {4'($urandom_range(3, 15)), 28'($urandom)};
      endcase
      htrans = 2'($urandom);
      hwrite = 1'($urandom);
      hrdata_s = {$urandom, $urandom, $urandom};
      for (int k = 0; k < 3; k++) hreadyout_s[k] = ($urandom_range(0, 3) != 0);
      hresp_s = 3'($urandom);
      @(negedge clk);
      d = ref_decode(haddr);
      e_hsel = (d >= 0) ? 3'(1 << d) : 3'b000;
      if (tgt < 0) begin
        e_rdy = 1'b1; e_rsp = 1'b0; e_data = '0;
      end else if (tgt < 3) begin
        e_rdy = hreadyout_s[tgt]; e_rsp = hresp_s[tgt]; e_data = hrdata_s[tgt*32 +: 32];
      end else begin
        e_rdy = (err_left == 1); e_rsp = 1'b1; e_data = '0;
      end
      checks++;
      if (hsel !== e_hsel || hready !== e_rdy || hresp !== e_rsp || hr_data !== e_data ||
          err_count !== 16'(exp_err)) begin
        errors++; bad++;
        if (bad <= 10)
          $display("FAIL random_%0d: got hsel=%b rdy=%b rsp=%b data=%h err=%0d want %b %b %b %h %0d",
                   n, hsel, hready, hresp, hr_data, err_count, e_hsel, e_rdy, e_rsp, e_data, exp_err);
      end
      if (e_rdy) begin
        if (htrans[1]) begin
          if (d >= 0) tgt = d;
          else begin
            tgt = 3; err_left = 2;
            if (exp_err < 65535) exp_err++;
          end
        end else begin
          tgt = -1;
        end
      end else if (tgt == 3) begin
        err_left--;
      end
      tick();
    end
    htrans = 2'b00;
    $display("test_random done: 300 transactions, %0d decode errors", exp_err);
  endtask

  initial begin
    test_reset();
    test_read();
    test_wait_states();
    test_unmapped_write();
    test_back_to_back();
    test_reset_in_err();
    test_overlap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
